// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/PC input side and
// decoded-immediate output side, both valid/ready.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_target;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: decodes the instruction format and
// immediate combinationally, then buffers the result in an output register
// backed by a single skid register so in_ready can come straight from a flop.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter bit TARGET_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic signed [XLEN-1:0] imm;
    logic [XLEN-1:0]        tgt;
    logic [2:0]             fmt;
    logic                   ill;
  } ent_t;

  typedef struct packed {
    logic signed [XLEN-1:0] imm;
    logic [2:0]             fmt;
    logic                   ill;
    logic                   use_tgt;
  } dec_t;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] shamt;
    d.imm     = '0;
    d.fmt     = FMT_ILL;
    d.ill     = 1'b0;
    d.use_tgt = 1'b0;
    // RV64 shifts carry a 6-bit shamt; RV32 only 5 bits
    shamt = (XLEN == 64) ? ins[25:20] : {1'b0, ins[24:20]};
    case (ins[6:0])
      7'b0110011: d.fmt = FMT_R;
      7'b0010011: begin
        d.fmt = FMT_I;
        if (ins[13:12] == 2'b01) d.imm = XLEN'(shamt);
        else                     d.imm = sext32({{20{ins[31]}}, ins[31:20]});
      end
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        d.fmt = FMT_I;
        d.imm = sext32({{20{ins[31]}}, ins[31:20]});
      end
      7'b0100011: begin
        d.fmt = FMT_S;
        d.imm = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
      end
      7'b1100011: begin
        d.fmt     = FMT_B;
        d.imm     = sext32({{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0});
        d.use_tgt = 1'b1;
      end
      7'b0110111: begin
        d.fmt = FMT_U;
        d.imm = sext32({ins[31:12], 12'b0});
      end
      7'b0010111: begin
        d.fmt     = FMT_U;
        d.imm     = sext32({ins[31:12], 12'b0});
        d.use_tgt = 1'b1;
      end
      7'b1101111: begin
        d.fmt     = FMT_J;
        d.imm     = sext32({{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0});
        d.use_tgt = 1'b1;
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  dec_t dec_p0;
  ent_t ent_p0;
  ent_t out_p1;
  ent_t sk_p1;
  logic vld_p1, vld_sk_p1, rdy_p1;
  logic vld_p1_d, vld_sk_d;
  logic acc, drain, out_free;
  logic ld_out_in, ld_out_sk, ld_sk;

  // ---- stage 0: combinational decode and target add ----
  always_comb begin
    dec_p0     = decode(bus.in_instr);
    ent_p0.imm = dec_p0.imm;
    ent_p0.fmt = dec_p0.fmt;
    ent_p0.ill = dec_p0.ill;
    ent_p0.tgt = (TARGET_EN && dec_p0.use_tgt) ? bus.in_pc + dec_p0.imm : '0;
  end

  always_comb begin
    acc       = bus.in_valid & rdy_p1;
    drain     = vld_p1 & bus.out_ready;
    out_free  = ~vld_p1 | drain;
    ld_out_sk = vld_sk_p1 & out_free;
    ld_out_in = acc & out_free & ~vld_sk_p1;
    ld_sk     = acc & ~out_free;
    vld_p1_d  = ld_out_sk | ld_out_in | (vld_p1 & ~drain);
    vld_sk_d  = ld_sk | (vld_sk_p1 & ~ld_out_sk);
  end

  // ---- stage 1: output register + skid register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_sk_p1 <= 1'b0;
      rdy_p1    <= 1'b0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      vld_sk_p1 <= 1'b0;
      rdy_p1    <= 1'b1;
    end else begin
      vld_p1    <= vld_p1_d;
      vld_sk_p1 <= vld_sk_d;
      rdy_p1    <= ~vld_sk_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_out_sk)      out_p1 <= sk_p1;
    else if (ld_out_in) out_p1 <= ent_p0;
    if (ld_sk)          sk_p1  <= ent_p0;
  end

  // Data flops carry no reset; fields read as zero whenever no entry is valid.
  assign bus.in_ready    = rdy_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.out_imm     = vld_p1 ? out_p1.imm : '0;
  assign bus.out_fmt     = vld_p1 ? out_p1.fmt : 3'd0;
  assign bus.out_illegal = vld_p1 & out_p1.ill;
  assign bus.out_target  = vld_p1 ? out_p1.tgt : '0;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 Parameter XLEN, default 32, meaning datapath width; legal values 32 or 64.
REQ-003 Parameter TARGET_EN, default 1, meaning the PC-relative target adder is present; when 0, out_target SHALL be tied to 0.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  drops all buffered entries.
REQ-007 in_valid  input  1  upstream holds a valid instruction.
REQ-008 in_ready  output  1  block can accept this cycle; driven directly from a register.
REQ-009 in_instr  input  32  RV32I/RV64I instruction word.
REQ-010 in_pc  input  XLEN  PC of in_instr.
REQ-011 out_valid  output  1  output entry valid.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 out_imm  output  XLEN  sign-extended, positioned immediate.
REQ-014 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-015 out_illegal  output  1  unrecognised opcode or instr[1:0]!=2'b11.
REQ-016 out_target  output  XLEN  in_pc+out_imm for B, J and AUIPC; 0 otherwise.

Function
REQ-017 Decode: OP 0110011 -> R, imm 0; OP-IMM 0010011, LOAD 0000011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011 -> I; STORE 0100011 -> S; BRANCH 1100011 -> B; LUI 0110111 and AUIPC 0010111 -> U; JAL 1101111 -> J; any other opcode -> ILL.
REQ-018 I imm SHALL be instr[31:20] sign-extended to XLEN; S imm SHALL be {instr[31:25],instr[11:7]} sign-extended.
REQ-019 B imm SHALL be {instr[31],instr[7],instr[30:25],instr[11:8],1'b0} sign-extended; J imm SHALL be {instr[31],instr[19:12],instr[20],instr[30:21],1'b0} sign-extended.
REQ-020 U imm SHALL be {instr[31:12],12'b0} sign-extended to XLEN.
REQ-021 For OP-IMM with funct3 001 or 101, imm SHALL be the zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-022 For ILL, out_imm, out_target and out_fmt SHALL be 0, 0 and 7, with out_illegal=1; for all other formats out_illegal=0.
REQ-023 out_target addition SHALL be modulo 2^XLEN; carry is discarded.
REQ-024 Storage SHALL be one output register plus one skid register; latency SHALL be exactly 1 cycle from acceptance to out_valid when the output register is free.
REQ-025 A transfer SHALL occur on in_valid&in_ready (input side) and on out_valid&out_ready (output side); decoding SHALL happen before registering.
REQ-026 An accepted entry SHALL load the output register if it is empty or drains in the same cycle; otherwise it SHALL load the skid register.
REQ-027 When the output drains and the skid register is full, the skid entry SHALL move to the output register and the skid register SHALL clear in the same edge.
REQ-028 in_ready SHALL be registered as !skid_valid for the next cycle; with the skid register full, no input SHALL be accepted.
REQ-029 Entries SHALL leave in acceptance order; none SHALL be duplicated or lost, except by flush.
REQ-030 Output fields SHALL be held stable while out_valid=1 and out_ready=0.
REQ-031 flush SHALL clear both valids at the next edge and set in_ready=1; flush SHALL override a simultaneous input acceptance, which is dropped.

Reset
REQ-032 While rst=1: out_valid=0, skid empty, in_ready=0, and out_imm, out_fmt, out_illegal and out_target SHALL be 0; in_ready=1 from the first cycle after rst deasserts.
REQ-033 rst SHALL take priority over flush, in_valid and out_ready; entries in flight at reset SHALL be discarded.

Verification
REQ-034 Accept 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1; then 0x4030D093 (srai x1,x1,3) -> imm=0x00000003.
REQ-035 Accept 0xFE000EE3 (beq x0,x0,-4), pc=0x100 -> imm=0xFFFFFFFC, fmt=3, target=0x000000FC; 0x123450B7 (lui) -> imm=0x12345000, fmt=4, target=0.
REQ-036 Hold out_ready=0 and present 3 back-to-back instructions -> first two accepted, in_ready=0 from the following cycle, third held; then raise out_ready -> order 1,2,3, one per cycle.
REQ-037 Fill both registers, then assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushing-cycle input is never output.
REQ-038 Accept 0x00000000 -> out_illegal=1, fmt=7, imm=0; with XLEN=64, 0x0000A033 (R) -> imm=0, and lui 0x800000B7 -> imm=0xFFFFFFFF80000000.
REQ-039 Assert rst with both registers full -> during rst in_ready=0 and out_valid=0; after rst, no stale entry appears.
